// File: rtl/fb_swap_writer_pkg.sv
// fb_swap_writer_pkg: frame-buffer geometry defaults, FSM state type and width helper.
package fb_swap_writer_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_HEIGHT = 8;
  localparam int DEF_PIXEL_SIZE = 1;
  typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} fb_state_t;
  // Never returns 0 so a 1-wide dimension still yields a legal vector.
  function automatic int clog2w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fb_raster_cnt.sv
// fb_raster_cnt: raster x/y position counter with advance, clear and load-after-origin.
module fb_raster_cnt import fb_swap_writer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         en,
  input  logic                         clr,
  input  logic                         org,
  output logic [clog2w(WIDTH)-1:0]     x,
  output logic [clog2w(HEIGHT)-1:0]    y,
  output logic                         last,
  output logic                         at_origin
);
  localparam int XW = clog2w(WIDTH);
  localparam int YW = clog2w(HEIGHT);
  logic x_end, y_end;
  assign x_end = x == XW'(WIDTH - 1);
  assign y_end = y == YW'(HEIGHT - 1);
  assign last = x_end && y_end;
  assign at_origin = x == '0 && y == '0;
  // org means "pixel (0,0) was just written": continue from the next column.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (org) begin
      x <= XW'(1);
      y <= '0;
    end else if (en) begin
      x <= x_end ? '0 : x + XW'(1);
      y <= x_end ? (y_end ? '0 : y + YW'(1)) : y;
    end
endmodule

// File: rtl/fb_swap_writer.sv
// fb_swap_writer: fills the back buffer from a raster pixel stream and swaps on scanout frame end.
// Optional FB_SWAP_WRITER_STATS_EN adds frame_count and drop_count outputs.
module fb_swap_writer import fb_swap_writer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int PIXEL_SIZE = DEF_PIXEL_SIZE
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PIXEL_SIZE-1:0]        in_pixel,
  input  logic                         in_sof,
  input  logic                         scan_frame_end,
  output logic                         wr_en,
  output logic                         wr_buf,
  output logic [clog2w(WIDTH)-1:0]     wr_x,
  output logic [clog2w(HEIGHT)-1:0]    wr_y,
  output logic [PIXEL_SIZE-1:0]        wr_data,
  output logic                         buf_sel,
  output logic                         swap_pending,
`ifdef FB_SWAP_WRITER_STATS_EN
  output logic [15:0]                  frame_count,
  output logic [15:0]                  drop_count,
`endif
  output logic                         sof_err
);
  localparam int XW = clog2w(WIDTH);
  localparam int YW = clog2w(HEIGHT);
  fb_state_t state, next;
  logic acc, wr, en, clr, org, swap, drop, err, last, at_origin;
  logic [XW-1:0] x, wx;
  logic [YW-1:0] y, wy;
  fb_raster_cnt #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_cnt (
    .clk(clk), .resetn(resetn), .en(en), .clr(clr), .org(org),
    .x(x), .y(y), .last(last), .at_origin(at_origin)
  );
  assign in_ready = resetn && state != WAIT_SWAP;
  assign acc = in_valid && in_ready;
  assign swap_pending = state == WAIT_SWAP;
  assign wr_buf = ~buf_sel;
  always_comb begin
    next = state;
    wr = 1'b0;
    wx = x;
    wy = y;
    en = 1'b0;
    clr = 1'b0;
    org = 1'b0;
    swap = 1'b0;
    drop = 1'b0;
    err = 1'b0;
    case (state)
      IDLE:
        if (acc) begin
          wr = in_sof;
          drop = !in_sof;
          org = in_sof;
          wx = '0;
          wy = '0;
          next = in_sof ? FILL : IDLE;
        end
      FILL:
        if (acc) begin
          wr = 1'b1;
          if (in_sof && !at_origin) begin
            wx = '0;
            wy = '0;
            org = 1'b1;
            err = 1'b1;
          end else if (last) begin
            clr = 1'b1;
            next = WAIT_SWAP;
          end else
            en = 1'b1;
        end
      WAIT_SWAP: begin
        swap = scan_frame_end;
        next = scan_frame_end ? IDLE : WAIT_SWAP;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      buf_sel <= 1'b0;
      sof_err <= 1'b0;
      wr_en <= 1'b0;
      wr_x <= '0;
      wr_y <= '0;
      wr_data <= '0;
    end else begin
      state <= next;
      buf_sel <= buf_sel ^ swap;
      sof_err <= sof_err | err;
      wr_en <= wr;
      if (wr) begin
        wr_x <= wx;
        wr_y <= wy;
        wr_data <= in_pixel;
      end
    end
`ifdef FB_SWAP_WRITER_STATS_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      frame_count <= '0;
      drop_count <= '0;
    end else begin
      frame_count <= frame_count + {15'd0, swap};
      drop_count <= (drop && drop_count != 16'hFFFF) ? drop_count + 16'd1 : drop_count;
    end
`endif
endmodule

// File: tb/tb_fb_swap_writer.sv
// tb_fb_swap_writer: directed checks of fill, swap, drop, sof restart and reset on a 4x2 buffer.
module tb_fb_swap_writer;
  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, in_sof = 1'b0, scan_frame_end = 1'b0;
  logic [3:0] in_pixel = '0;
  logic in_ready, wr_en, wr_buf, buf_sel, swap_pending, sof_err;
  logic [1:0] wr_x;
  logic [0:0] wr_y;
  logic [3:0] wr_data;
`ifdef FB_SWAP_WRITER_STATS_EN
  logic [15:0] frame_count, drop_count;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  fb_swap_writer #(.WIDTH(4), .HEIGHT(2), .PIXEL_SIZE(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof), .scan_frame_end(scan_frame_end),
    .wr_en(wr_en), .wr_buf(wr_buf), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .buf_sel(buf_sel), .swap_pending(swap_pending),
`ifdef FB_SWAP_WRITER_STATS_EN
    .frame_count(frame_count), .drop_count(drop_count),
`endif
    .sof_err(sof_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Present one pixel for one cycle, then check the registered write it produced.
  task automatic px(input logic [3:0] d, input logic s, input logic ew, input int ex, input int ey,
                    input logic eb, input logic sfe);
    @(negedge clk);
    in_valid = 1'b1;
    in_pixel = d;
    in_sof = s;
    scan_frame_end = sfe;
    @(posedge clk);
    #1;
    chk("wr_en", wr_en, ew);
    if (ew) begin
      chk("wr_x", wr_x, ex);
      chk("wr_y", wr_y, ey);
      chk("wr_data", wr_data, d);
      chk("wr_buf", wr_buf, eb);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof = 1'b0;
      scan_frame_end = 1'b0;
    end
  endtask
  task automatic pulse_sfe();
    @(negedge clk);
    in_valid = 1'b0;
    scan_frame_end = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    scan_frame_end = 1'b0;
  endtask
  task automatic frame(input logic eb, input logic sfe_last);
    for (int i = 0; i < 8; i++)
      px(4'(i + 1), i == 0, 1'b1, i % 4, i / 4, eb, sfe_last && i == 7);
    chk("swap_pending_full", swap_pending, 1);
    chk("in_ready_full", in_ready, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_buf_sel", buf_sel, 0);
    chk("rst_wr_buf", wr_buf, 1);
    chk("rst_swap_pending", swap_pending, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_wr_xy_data", {wr_x, wr_y, wr_data}, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("in_ready_idle", in_ready, 1);
    frame(1'b1, 1'b0);
    idle(1);
    @(posedge clk);
    #1;
    chk("wr_en_after_frame", wr_en, 0);
    chk("buf_sel_wait", buf_sel, 0);
    chk("in_ready_wait", in_ready, 0);
    pulse_sfe();
    chk("buf_sel_swapped", buf_sel, 1);
    chk("swap_pending_clr", swap_pending, 0);
    chk("in_ready_after_swap", in_ready, 1);
    chk("wr_buf_after_swap", wr_buf, 0);
`ifdef FB_SWAP_WRITER_STATS_EN
    chk("frame_count_1", frame_count, 1);
`endif
    for (int i = 0; i < 3; i++) px(4'(9 + i), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
`ifdef FB_SWAP_WRITER_STATS_EN
    chk("drop_count_3", drop_count, 3);
`endif
    pulse_sfe();
    chk("sfe_idle_ignored", buf_sel, 1);
    px(4'd1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    px(4'd2, 1'b0, 1'b1, 1, 0, 1'b0, 1'b1);
    chk("sfe_fill_ignored", buf_sel, 1);
    px(4'd3, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0);
    idle(2);
    @(posedge clk);
    #1;
    chk("gap_no_write", wr_en, 0);
    px(4'd4, 1'b0, 1'b1, 3, 0, 1'b0, 1'b0);
    chk("sof_err_before", sof_err, 0);
    px(4'd5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    chk("sof_err_set", sof_err, 1);
    for (int i = 0; i < 6; i++) begin
      px(4'(6 + i), 1'b0, 1'b1, (i + 1) % 4, (i + 1) / 4, 1'b0, 1'b0);
      chk("restart_not_done", swap_pending, 0);
    end
    px(4'd12, 1'b0, 1'b1, 3, 1, 1'b0, 1'b0);
    chk("restart_done", swap_pending, 1);
    pulse_sfe();
    chk("buf_sel_back_0", buf_sel, 0);
    frame(1'b1, 1'b1);
    chk("coincident_no_swap", buf_sel, 0);
    idle(1);
    @(posedge clk);
    #1;
    chk("still_pending", swap_pending, 1);
    chk("sof_err_sticky", sof_err, 1);
    pulse_sfe();
    chk("swap_next_pulse", buf_sel, 1);
    px(4'd1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    px(4'd2, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
    px(4'd3, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_buf_sel", buf_sel, 0);
    chk("mid_rst_wr_buf", wr_buf, 1);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_sof_err", sof_err, 0);
    chk("mid_rst_xy", {wr_x, wr_y, wr_data}, 0);
    @(negedge clk);
    resetn = 1'b1;
    frame(1'b1, 1'b0);
    chk("post_rst_buf_sel", buf_sel, 0);
    idle(1);
    pulse_sfe();
    chk("post_rst_swap", buf_sel, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
